// File: rtl/usb_enc_pkg.sv
// Shared types and field sizes for the USB packet serializer.
// Field helpers used by both the datapath and its shifter loads.
package usb_enc_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        TOKEN  = 2'b01,
        HSHAKE = 2'b10,
        DATA   = 2'b11
    } pkt_type_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_BODY,
        S_END_WAIT
    } ser_state_t;

    localparam int PID_BITS        = 8;
    localparam int TOKEN_BODY_BITS = 11;

    function automatic logic [PID_BITS-1:0] pid_field(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_ser_shifter.sv
// Loadable parallel-in serial-out shifter.
// Fields are pre-aligned by the caller so the serial bit is always at one end.
module usb_ser_shifter #(
    parameter int W         = 64,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    output logic         bit_out
);

    logic [W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_val;
        end else if (shift) begin
            sreg <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
        end
    end

    assign bit_out = LSB_FIRST ? sreg[0] : sreg[W-1];

endmodule

// File: rtl/usb_pkt_serializer.sv
// Serialises SYNC, PID and token/data body into one back-pressured bit stream.
// One shared shifter carries PID first, then is reloaded with the body.
module usb_pkt_serializer
    import usb_enc_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 8,
    parameter int SYNC_BITS      = 8,
    parameter bit LSB_FIRST      = 1'b1,
    localparam int DW = 8 * MAX_DATA_BYTES,
    localparam int LW = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pkt_type,
    input  logic [3:0]    pid,
    input  logic [10:0]   token,
    input  logic [DW-1:0] data,
    input  logic [LW-1:0] data_len,
    output logic          free_inbound,
    output logic          s_out,
    output logic          s_valid,
    input  logic          s_ready,
    output logic          crc_en,
    output logic [1:0]    pkt_in,
    output logic          endr,
    input  logic          sent_pkt,
    output logic          len_err
);

    localparam int SW = (DW > TOKEN_BODY_BITS) ? DW : TOKEN_BODY_BITS;
    localparam int CW = $clog2(DW + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_DATA_BYTES);

    ser_state_t state, state_n;
    pkt_type_t  type_q;
    logic [10:0]   token_q;
    logic [DW-1:0] data_q;
    logic [LW-1:0] len_q;
    logic [CW-1:0] cnt, last_idx;
    logic accept, fire, last, has_body;
    logic load, shift, sh_bit;
    logic [SW-1:0] load_val, pid_val, token_val, data_val;

    assign accept   = (state == S_IDLE) && (pkt_type != 2'b00);
    assign fire     = s_valid && s_ready;
    assign has_body = (type_q == TOKEN) ||
                      ((type_q == DATA) && (len_q != '0));
    assign last     = (cnt == last_idx);

    always_comb begin
        last_idx = '0;
        unique case (state)
            S_SYNC: last_idx = CW'(SYNC_BITS - 1);
            S_PID:  last_idx = CW'(PID_BITS - 1);
            S_BODY: last_idx = (type_q == TOKEN) ?
                               CW'(TOKEN_BODY_BITS - 1) :
                               CW'({len_q, 3'b000}) - CW'(1);
            default: last_idx = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:     if (accept) state_n = S_SYNC;
            S_SYNC:     if (fire && last) state_n = S_PID;
            S_PID:      if (fire && last) state_n = has_body ? S_BODY : S_END_WAIT;
            S_BODY:     if (fire && last) state_n = S_END_WAIT;
            S_END_WAIT: if (sent_pkt) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            type_q  <= NONE;
            token_q <= '0;
            data_q  <= '0;
            len_q   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                cnt <= '0;
            end else if (fire) begin
                cnt <= cnt + CW'(1);
            end
            if (accept) begin
                type_q  <= pkt_type_t'(pkt_type);
                token_q <= token;
                data_q  <= data;
                len_q   <= (data_len > MAX_LEN) ? MAX_LEN : data_len;
            end
        end
    end

    // MSB-first fields are left-aligned; data bytes keep byte 0 first.
    always_comb begin
        data_val = '0;
        for (int k = 0; k < MAX_DATA_BYTES; k++) begin
            if (LSB_FIRST) data_val[8*k +: 8] = data_q[8*k +: 8];
            else           data_val[SW-8-8*k +: 8] = data_q[8*k +: 8];
        end
    end

    assign pid_val   = LSB_FIRST ? SW'(pid_field(pid)) :
                       SW'(pid_field(pid)) << (SW - PID_BITS);
    assign token_val = LSB_FIRST ? SW'(token_q) :
                       SW'(token_q) << (SW - TOKEN_BODY_BITS);

    assign load     = accept || ((state == S_PID) && fire && last && has_body);
    assign load_val = accept ? pid_val :
                      ((type_q == TOKEN) ? token_val : data_val);
    assign shift    = fire && ((state == S_PID) || (state == S_BODY));

    usb_ser_shifter #(
        .W         (SW),
        .LSB_FIRST (LSB_FIRST)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .shift    (shift),
        .bit_out  (sh_bit)
    );

    assign s_valid      = (state == S_SYNC) || (state == S_PID) || (state == S_BODY);
    assign s_out        = s_valid &&
                          ((state == S_SYNC) ? (cnt == CW'(SYNC_BITS - 1)) : sh_bit);
    assign crc_en       = (state == S_BODY);
    assign endr         = (state == S_END_WAIT);
    assign free_inbound = (state == S_IDLE);
    assign pkt_in       = (state == S_IDLE) ? 2'b00 : 2'(type_q);
    assign len_err      = !rst && accept && (pkt_type == DATA) &&
                          (data_len > MAX_LEN);

endmodule
